// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory from address 0,
// then releases the core and waits for it to halt.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  input  logic              halted,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_t          state;
  state_t          state_n;
  logic            hs;
  logic            restart;
  logic            ovf;
  logic [ADDR_W:0] cnt_inc;

  assign hs      = in_valid & in_ready;
  assign cnt_inc = word_count + (ADDR_W+1)'(1);
  assign restart = start & ((state == IDLE) | (state == DONE));
  assign ovf     = hs & ~in_last & (cnt_inc == MAX_CNT);

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    core_run = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs && in_last) state_n = FLUSH;
        else if (ovf)      state_n = ERR;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        core_run = 1'b1;
        busy     = 1'b1;
        if (halted) state_n = DONE;
      end
      DONE: begin
        if (start) state_n = LOAD;
      end
      ERR: begin
        state_n = ERR;
      end
      default: state_n = IDLE;
    endcase
  end

  // The write is registered, so it lands one cycle after its handshake.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      checksum   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state  <= state_n;
      mem_we <= hs;
      if (hs) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        word_count <= cnt_inc;
        checksum   <= checksum + in_data;
      end
      if (restart) begin
        word_count <= '0;
        checksum   <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
      end
      if (state == RUN && halted) done <= 1'b1;
      if (ovf) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of images plus overflow
// and mid-load reset sequences, writes checked by a scoreboard.
module tb_imem_boot_loader;

  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;

  logic          a_start = 0, a_valid = 0, a_last = 0, a_halted = 0;
  logic [31:0]   a_data = '0;
  logic          a_in_ready, a_mem_we, a_core_run, a_busy, a_done, a_err;
  logic [AW-1:0] a_mem_addr;
  logic [31:0]   a_mem_wdata, a_checksum;
  logic [AW:0]   a_word_count;

  logic          b_start = 0, b_valid = 0, b_last = 0, b_halted = 0;
  logic [31:0]   b_data = '0;
  logic          b_in_ready, b_mem_we, b_core_run, b_busy, b_done, b_err;
  logic [AW-1:0] b_mem_addr;
  logic [31:0]   b_mem_wdata, b_checksum;
  logic [AW:0]   b_word_count;

  always #5 clk1 = ~clk1;

  imem_boot_loader #(.ADDR_W(AW), .MAX_WORDS(1024)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(a_start),
    .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
    .in_ready(a_in_ready), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .core_run(a_core_run), .halted(a_halted), .busy(a_busy),
    .done(a_done), .err(a_err), .word_count(a_word_count),
    .checksum(a_checksum)
  );

  imem_boot_loader #(.ADDR_W(AW), .MAX_WORDS(4)) dut4 (
    .clk1(clk1), .rst_n(rst_n), .start(b_start),
    .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
    .in_ready(b_in_ready), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .core_run(b_core_run), .halted(b_halted), .busy(b_busy),
    .done(b_done), .err(b_err), .word_count(b_word_count),
    .checksum(b_checksum)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  logic [AW-1:0] a_exp_addr = '0;
  logic [AW-1:0] b_exp_addr = '0;

  typedef struct packed {
    logic [9:0][31:0] img;
    logic [3:0]       n;
    logic             gaps;
    logic [31:0]      sum;
    logic [AW:0]      cnt;
  } vec_t;

  vec_t vt [3];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic send_a(input logic [31:0] d, input logic last);
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    if (a_in_ready) begin
      qa.push_back('{a_exp_addr, d});
      a_exp_addr++;
    end
    step();
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d);
    b_valid = 1'b1;
    b_data  = d;
    b_last  = 1'b0;
    if (b_in_ready) begin
      qb.push_back('{b_exp_addr, d});
      b_exp_addr++;
    end
    step();
    b_valid = 1'b0;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_exp_addr = '0;
  endtask

  task automatic wait_run_a();
    int k;
    k = 0;
    while (!a_core_run && k < 20) begin
      step();
      k++;
    end
    check("a_run_timeout", 64'(a_core_run), 64'(1));
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_in_ready"}, 64'(a_in_ready), 64'(0));
    check({tag, "_mem_we"}, 64'(a_mem_we), 64'(0));
    check({tag, "_mem_addr"}, 64'(a_mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(a_mem_wdata), 64'(0));
    check({tag, "_core_run"}, 64'(a_core_run), 64'(0));
    check({tag, "_busy"}, 64'(a_busy), 64'(0));
    check({tag, "_done"}, 64'(a_done), 64'(0));
    check({tag, "_err"}, 64'(a_err), 64'(0));
    check({tag, "_word_count"}, 64'(a_word_count), 64'(0));
    check({tag, "_checksum"}, 64'(a_checksum), 64'(0));
  endtask

  logic a_we_d = 1'b0;
  logic a_run_d = 1'b0;
  logic b_run_seen = 1'b0;

  always @(negedge clk1) begin
    if (a_mem_we) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_spurious_we: got write at %0h expected none",
                 a_mem_addr);
      end else begin
        wr_t e;
        e = qa.pop_front();
        check("a_wr_addr", 64'(a_mem_addr), 64'(e.addr));
        check("a_wr_data", 64'(a_mem_wdata), 64'(e.data));
      end
    end
    if (b_mem_we) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_spurious_we: got write at %0h expected none",
                 b_mem_addr);
      end else begin
        wr_t e;
        e = qb.pop_front();
        check("b_wr_addr", 64'(b_mem_addr), 64'(e.addr));
        check("b_wr_data", 64'(b_mem_wdata), 64'(e.data));
      end
    end
    if (a_core_run && !a_run_d)
      check("a_run_after_we", 64'(a_we_d), 64'(1));
    if (a_core_run)
      check("a_run_we_excl", 64'(a_mem_we), 64'(0));
    if (b_core_run) b_run_seen = 1'b1;
    a_we_d  = a_mem_we;
    a_run_d = a_core_run;
  end

  logic [9:0][31:0] happy;
  logic [9:0][31:0] wrap;

  initial begin
    happy = '0;
    happy[0] = 32'h2401000A;
    happy[1] = 32'h24020014;
    happy[2] = 32'h24030019;
    happy[3] = 32'h0CE73800;
    happy[4] = 32'h0CE73800;
    happy[5] = 32'h00222000;
    happy[6] = 32'h0CE73800;
    happy[7] = 32'h0CE73800;
    happy[8] = 32'h00832800;
    happy[9] = 32'h18000000;
    wrap = '0;
    wrap[0] = 32'h00000001;
    wrap[1] = 32'hFFFFFFFF;

    vt[0] = '{happy, 4'd10, 1'b0, 32'hB8482837, 11'd10};
    vt[1] = '{happy, 4'd10, 1'b1, 32'hB8482837, 11'd10};
    vt[2] = '{wrap,  4'd2,  1'b0, 32'h00000000, 11'd2};

    rst_n = 1'b0;
    repeat (2) step();
    check_zero_a("rst");
    check("rst_b_err", 64'(b_err), 64'(0));
    rst_n = 1'b1;
    step();
    check("idle_ready", 64'(a_in_ready), 64'(0));

    for (int v = 0; v < 3; v++) begin
      int n;
      n = int'(vt[v].n);
      start_a();
      check("start_ready", 64'(a_in_ready), 64'(1));
      check("start_busy", 64'(a_busy), 64'(1));
      check("start_done_clr", 64'(a_done), 64'(0));
      check("start_cnt_clr", 64'(a_word_count), 64'(0));
      check("start_sum_clr", 64'(a_checksum), 64'(0));
      for (int i = 0; i < n; i++) begin
        if (vt[v].gaps) repeat ($urandom_range(0, 3)) step();
        send_a(vt[v].img[i], i == n - 1);
      end
      check("flush_ready", 64'(a_in_ready), 64'(0));
      wait_run_a();
      check("load_count", 64'(a_word_count), 64'(vt[v].cnt));
      check("load_sum", 64'(a_checksum), 64'(vt[v].sum));
      check("run_busy", 64'(a_busy), 64'(1));
      a_start = 1'b1;
      repeat (20) step();
      a_start = 1'b0;
      check("run_hold", 64'(a_core_run), 64'(1));
      check("run_done_low", 64'(a_done), 64'(0));
      check("run_queue", 64'(qa.size()), 64'(0));
      a_halted = 1'b1;
      step();
      a_halted = 1'b0;
      check("halt_run", 64'(a_core_run), 64'(0));
      check("halt_done", 64'(a_done), 64'(1));
      check("halt_busy", 64'(a_busy), 64'(0));
    end

    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_exp_addr = '0;
    for (int i = 0; i < 4; i++) send_b(32'h100 + 32'(i));
    check("ovf_err", 64'(b_err), 64'(1));
    check("ovf_ready", 64'(b_in_ready), 64'(0));
    check("ovf_busy", 64'(b_busy), 64'(0));
    check("ovf_count", 64'(b_word_count), 64'(4));
    repeat (3) step();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    step();
    check("ovf_start_ign", 64'(b_in_ready), 64'(0));
    check("ovf_err_stick", 64'(b_err), 64'(1));
    send_b(32'hDEADBEEF);
    repeat (3) step();
    check("ovf_no_run", 64'(b_run_seen), 64'(0));
    check("ovf_queue", 64'(qb.size()), 64'(0));

    start_a();
    for (int i = 0; i < 5; i++) send_a(happy[i], 1'b0);
    rst_n = 1'b0;
    step();
    check_zero_a("midrst");
    check("midrst_b_err", 64'(b_err), 64'(0));
    rst_n = 1'b1;
    step();
    check("midrst_queue", 64'(qa.size()), 64'(0));

    start_a();
    send_a(32'h00000001, 1'b0);
    send_a(32'hFFFFFFFF, 1'b1);
    wait_run_a();
    check("reload_count", 64'(a_word_count), 64'(2));
    check("reload_sum", 64'(a_checksum), 64'(0));
    repeat (2) step();
    check("end_queue", 64'(qa.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
